// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths and FSM state encoding for the SPI initiator
package spi_pkg;
  localparam int SPI_DATA_W    = 8;
  localparam int SPI_BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;
endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - SCLK half-period tick generator, one pulse every CLK_DIV cycles
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst || clr)
      cnt <= 8'd0;
    else if (cnt == LAST)
      cnt <= 8'd0;
    else
      cnt <= cnt + 8'd1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - byte-wide SPI mode-0 initiator; SPI_MASTER_LSB_FIRST_EN selects LSB-first order
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  tx_en_i,
  input  logic [SPI_DATA_W-1:0] tx_data_i,
  input  logic                  spi_miso_i,
  output logic                  spi_csn_o,
  output logic                  spi_clk_o,
  output logic                  spi_mosi_o,
  output logic                  busy_o,
  output logic [SPI_DATA_W-1:0] rx_data_o,
  output logic                  rx_done_o
);
  generate
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("spi_master: CLK_DIV must be in 2..255");
    end
  endgenerate

  spi_state_e              state, next_state;
  logic                    tick;
  logic                    accept;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt;
  logic [SPI_DATA_W-1:0]   tx_sr;
  logic [SPI_DATA_W-1:0]   rx_sr;
  logic                    first_bit;
  logic                    next_bit;
  logic [SPI_DATA_W-1:0]   tx_shifted;
  logic [SPI_DATA_W-1:0]   rx_shifted;

  assign accept = (state == IDLE) && tx_en_i;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign first_bit  = tx_data_i[0];
  assign next_bit   = tx_sr[1];
  assign tx_shifted = {1'b0, tx_sr[SPI_DATA_W-1:1]};
  assign rx_shifted = {spi_miso_i, rx_sr[SPI_DATA_W-1:1]};
`else
  assign first_bit  = tx_data_i[SPI_DATA_W-1];
  assign next_bit   = tx_sr[SPI_DATA_W-2];
  assign tx_shifted = {tx_sr[SPI_DATA_W-2:0], 1'b0};
  assign rx_shifted = {rx_sr[SPI_DATA_W-2:0], spi_miso_i};
`endif

  // Restarting the divider on acceptance anchors every SCLK edge to the accept cycle.
  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk_i (clk_i),
    .rst   (rst),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tx_en_i) next_state = SETUP;
      SETUP:   if (tick) next_state = SHIFT;
      SHIFT:   if (tick && spi_clk_o && (bit_cnt == '0)) next_state = HOLD;
      HOLD:    if (tick) next_state = GAP;
      GAP:     if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      spi_csn_o  <= 1'b1;
      spi_clk_o  <= 1'b0;
      spi_mosi_o <= 1'b0;
      busy_o     <= 1'b0;
      rx_data_o  <= '0;
      rx_done_o  <= 1'b0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
    end else begin
      rx_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_en_i) begin
            tx_sr      <= tx_data_i;
            spi_csn_o  <= 1'b0;
            spi_mosi_o <= first_bit;
            busy_o     <= 1'b1;
            bit_cnt    <= '0;
          end
        end
        SETUP, SHIFT: begin
          if (tick) begin
            if (!spi_clk_o) begin
              spi_clk_o <= 1'b1;
              rx_sr     <= rx_shifted;
              bit_cnt   <= bit_cnt + 1'b1;
            end else begin
              // A wrapped bit counter on a falling edge means all eight bits are out.
              spi_clk_o <= 1'b0;
              if (bit_cnt == '0) begin
                spi_mosi_o <= 1'b0;
              end else begin
                tx_sr      <= tx_shifted;
                spi_mosi_o <= next_bit;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            spi_csn_o <= 1'b1;
            rx_data_o <= rx_sr;
            rx_done_o <= 1'b1;
          end
        end
        GAP: begin
          if (tick) busy_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master with an MSB-first mode-0 slave model
module tb_spi_master;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso = 1'b0;
  logic       csn, sclk, mosi, busy, rx_done;
  logic [7:0] rx_data;
  logic [7:0] slave_sr = 8'h00;

  int checks = 0;
  int errors = 0;

  spi_master #(.CLK_DIV(D)) dut (
    .clk_i      (clk),
    .rst        (rst),
    .tx_en_i    (tx_en),
    .tx_data_i  (tx_data),
    .spi_miso_i (miso),
    .spi_csn_o  (csn),
    .spi_clk_o  (sclk),
    .spi_mosi_o (mosi),
    .busy_o     (busy),
    .rx_data_o  (rx_data),
    .rx_done_o  (rx_done)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: next bit presented on every SCLK falling edge while selected.
  always @(negedge sclk) begin
    if (!csn) begin
      slave_sr = {slave_sr[6:0], 1'b0};
      miso = slave_sr[7];
    end
  end

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] exp_mosi_seq(input logic [7:0] tx);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return rev8(tx);
`else
    return tx;
`endif
  endfunction

  function automatic logic [7:0] exp_rx_of(input logic [7:0] sb);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return rev8(sb);
`else
    return sb;
`endif
  endfunction

  // Caller sits just after a negedge. pulse_at/abort_at name the edge that samples tx_en/rst.
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] sbyte,
                           input int pulse_at, input int abort_at, input string name);
    logic [7:0] seq, cap, exp_rx;
    int nrise, ndone, busy_fall;
    logic prev_sclk;
    seq = exp_mosi_seq(tx);
    exp_rx = exp_rx_of(sbyte);
    slave_sr = sbyte;
    miso = sbyte[7];
    tx_en = 1'b1;
    tx_data = tx;
    @(negedge clk);
    tx_en = 1'b0;
    tx_data = 8'($urandom);
    checks++;
    if (csn !== 1'b0 || busy !== 1'b1 || mosi !== seq[7]) begin
      errors++;
      $display("FAIL %s accept: csn=%b busy=%b mosi=%b, want csn=0 busy=1 mosi=%b",
               name, csn, busy, mosi, seq[7]);
    end
    nrise = 0; ndone = 0; busy_fall = -1; cap = 8'h00; prev_sclk = 1'b0;
    for (int cyc = 1; cyc <= 18 * D; cyc++) begin
      tx_en = (cyc == pulse_at);
      if (cyc == pulse_at) tx_data = 8'hFF;
      rst = (cyc == abort_at);
      @(negedge clk);
      tx_en = 1'b0;
      if (cyc == abort_at) begin
        rst = 1'b0;
        checks++;
        if (csn !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || mosi !== 1'b0 || rx_done !== 1'b0) begin
          errors++;
          $display("FAIL %s abort: csn=%b sclk=%b busy=%b mosi=%b done=%b, want 1 0 0 0 0",
                   name, csn, sclk, busy, mosi, rx_done);
        end
        for (int k = 0; k < 20 * D; k++) begin
          @(negedge clk);
          if (rx_done === 1'b1 || csn !== 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
          errors++;
          $display("FAIL %s post_abort: %0d cycles with rx_done or csn low, want 0", name, ndone);
        end
        return;
      end
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        checks++;
        if (cyc != D * (2 * nrise + 1)) begin
          errors++;
          $display("FAIL %s rise%0d_time: cycle %0d, want %0d", name, nrise, cyc, D * (2 * nrise + 1));
        end
        cap = {cap[6:0], mosi};
        nrise++;
      end
      prev_sclk = sclk;
      if (rx_done === 1'b1) begin
        ndone++;
        checks++;
        if (cyc != 17 * D || rx_data !== exp_rx || csn !== 1'b1 || mosi !== 1'b0) begin
          errors++;
          $display("FAIL %s rx_done: cycle %0d rx=%h csn=%b mosi=%b, want cycle %0d rx=%h csn=1 mosi=0",
                   name, cyc, rx_data, csn, mosi, 17 * D, exp_rx);
        end
      end
      if (busy === 1'b0 && busy_fall < 0) busy_fall = cyc;
    end
    checks++;
    if (nrise != 8 || cap !== seq) begin
      errors++;
      $display("FAIL %s mosi_bits: %0d rises bits=%h, want 8 rises bits=%h", name, nrise, cap, seq);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL %s done_count: %0d, want 1", name, ndone);
    end
    checks++;
    if (busy_fall != 18 * D || rx_data !== exp_rx) begin
      errors++;
      $display("FAIL %s busy_fall: cycle %0d rx=%h, want cycle %0d rx=%h", name, busy_fall, rx_data, 18 * D, exp_rx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_en = 1'($urandom);
      tx_data = 8'($urandom);
      miso = 1'($urandom);
      @(negedge clk);
      checks++;
      if (csn !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 ||
          rx_data !== 8'h00 || rx_done !== 1'b0) begin
        errors++;
        $display("FAIL reset%0d: csn=%b sclk=%b mosi=%b busy=%b rx=%h done=%b, want 1 0 0 0 00 0",
                 i, csn, sclk, mosi, busy, rx_data, rx_done);
      end
    end
    rst = 1'b0;
    tx_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (csn !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: csn=%b busy=%b, want 1 0", csn, busy);
    end
  endtask

  task automatic test_single_byte();
    run_frame(8'hA5, 8'h3C, -1, -1, "single_a5");
  endtask

  task automatic test_patterns();
    run_frame(8'h07, 8'hC3, -1, -1, "byte_07");
    run_frame(8'h00, 8'hFF, -1, -1, "byte_00");
  endtask

  task automatic test_back_to_back();
    run_frame(8'h5E, 8'h96, 10, -1, "busy_first");
    run_frame(8'hFF, 8'h12, -1, -1, "busy_second");
  endtask

  task automatic test_abort();
    run_frame(8'hC6, 8'h99, -1, 31, "abort");
    run_frame(8'h81, 8'h5A, -1, -1, "after_abort");
  endtask

  task automatic test_lsb_first();
`ifdef SPI_MASTER_LSB_FIRST_EN
    run_frame(8'h01, 8'h80, -1, -1, "lsb_01");
    checks++;
    if (rx_data !== 8'h01) begin
      errors++;
      $display("FAIL lsb_rx: rx=%h, want 01", rx_data);
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_patterns();
    test_back_to_back();
    test_abort();
    test_lsb_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
